timer_seq_ctrl: RTL and testbench
=================================

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADR, default 32'h44a00000, timer register base; CTRL at +0x0 (bit0 MODE, bit1 GO_EN), TOT_CNT at +0x4, DUTY_CNT at +0x8.
REQ-002 The block SHALL have port PCLK  in  1  the only clock; all logic on the rising edge.
REQ-003 The block SHALL have port PRESETn  in  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  in  1  one-cycle request to program and run the timer.
REQ-005 The block SHALL have port stop  in  1  one-cycle request to halt the timer.
REQ-006 The block SHALL have port mode  in  1  0 = counter, 1 = PWM; sampled with start.
REQ-007 The block SHALL have ports tot_cnt and duty_cnt  in  32 each  period and duty; sampled with start.
REQ-008 The block SHALL have port irq  in  1  timer IRQ, level.
REQ-009 The block SHALL have ports busy, done and err  out  1 each  sequence active, completion pulse, sticky error.
REQ-010 The block SHALL have APB master ports PADDR (out 32), PSEL (out 1), PENABLE (out 1), PWRITE (out 1), PWDATA (out 32), PREADY (in 1), PRDATA (in 32) and PSLVERR (in 1).

Function
REQ-011 Each APB transfer SHALL use one SETUP cycle (PSEL=1, PENABLE=0), then ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through completion.
REQ-012 Between transfers PSEL and PENABLE SHALL return to 0 for at least one cycle.
REQ-013 States: IDLE, W_CTRL0, W_TOT, W_DUTY, W_GO, R_CHK, RUN, W_CLR.
REQ-014 In IDLE, start SHALL latch mode, tot_cnt and duty_cnt, clear err and set busy on the next edge; SETUP of W_CTRL0 SHALL follow in the next cycle.
REQ-015 If start is asserted while busy=1, the block SHALL ignore it.
REQ-016 W_CTRL0 SHALL write CTRL={GO_EN=0,MODE=mode}; W_TOT SHALL write TOT_CNT; W_DUTY SHALL write DUTY_CNT and SHALL execute only when mode=1, otherwise it is skipped; W_GO SHALL write CTRL={1,mode}.
REQ-017 R_CHK SHALL read CTRL; if PRDATA[1:0] != {1,mode}, the block SHALL set err and go to W_CLR; otherwise it SHALL go to RUN.
REQ-018 In RUN with mode=0, the first cycle where irq=1 SHALL cause a transition to W_CLR.
REQ-019 In RUN with mode=1, the block SHALL stay in RUN until stop.
REQ-020 W_CLR SHALL write CTRL=0x0, stopping the timer and clearing its IRQ; on completion the block SHALL go to IDLE, deassert busy, and pulse done for exactly one cycle if no error occurred.
REQ-021 A stop received during any programming state or R_CHK SHALL be remembered; the current transfer SHALL complete, after which the block SHALL go to W_CLR and done SHALL pulse.
REQ-022 A stop received in IDLE SHALL be ignored.
REQ-023 If irq=1 and stop=1 arrive in the same RUN cycle, the block SHALL perform a single W_CLR.
REQ-024 If PSLVERR=1 is sampled with PREADY=1 on any transfer other than W_CLR, the block SHALL set err and go to W_CLR.
REQ-025 If PSLVERR=1 is sampled on W_CLR, the block SHALL set err and go to IDLE.
REQ-026 done SHALL NOT pulse when err is set.
REQ-027 Argument check on start: if tot_cnt==0, or if mode=1 and duty_cnt>tot_cnt, the block SHALL set err, issue no APB transfer, and keep busy=0.
REQ-028 duty_cnt==tot_cnt with mode=1 SHALL be accepted.
REQ-029 err SHALL stay high until the next accepted start.
REQ-030 PREADY held low SHALL extend ACCESS indefinitely; the block SHALL have no timeout.

Reset
REQ-031 PRESETn=0 SHALL immediately force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0, done=0, err=0, and clear the pending-stop flag and latched configuration.
REQ-032 Reset during a transfer SHALL abandon it, with no completion.
REQ-033 The first start accepted after reset release SHALL behave as in REQ-014.

Verification
REQ-034 The bench SHALL cover counter mode: start with mode=0, tot=128 -> writes 0x0@+0, 128@+4, 0x2@+0, then read +0=0x2; RUN until irq; write 0x0@+0; done pulses once; busy then low.
REQ-035 The bench SHALL cover PWM mode: mode=1, tot=64, duty=25 -> writes 0x1, 64, 25@+8, 0x3; read returns 0x3; stop after 600 cycles -> write 0x0@+0; done pulses.
REQ-036 The bench SHALL cover a slave error: PSLVERR=1 on the TOT_CNT write -> err=1, no DUTY/GO write, 0x0 written to CTRL, no done pulse, and err clears on the next valid start.
REQ-037 The bench SHALL cover argument checks: tot=0 -> err=1 with no PSEL activity; mode=1, tot=10, duty=11 -> err=1; mode=1, tot=10, duty=10 -> accepted.
REQ-038 The bench SHALL cover wait states and collisions: PREADY low for 3 cycles on each transfer keeps the address and data stable; stop during W_TOT -> W_TOT completes, then CTRL=0, done; start while busy is ignored.
REQ-039 The bench SHALL cover reset: PRESETn low in the ACCESS phase of W_GO -> all outputs are 0 immediately; a later start reprograms from W_CTRL0.

Source files
------------

// File: rtl/timer_seq_ctrl.sv
// APB master sequencer that programs, runs and tears down a timer peripheral.
// Each transfer state walks GAP -> SETUP -> ACCESS; APB outputs decode from state.
module timer_seq_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h44a00000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [31:0] tot_cnt,
  input  logic [31:0] duty_cnt,
  input  logic        irq,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);
  typedef enum logic [2:0] {
    S_IDLE, S_W_CTRL0, S_W_TOT, S_W_DUTY, S_W_GO, S_R_CHK, S_RUN, S_W_CLR
  } state_t;
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t      r_state, w_nstate;
  phase_t      r_ph, w_nph;
  logic        r_stop, w_nstop;
  logic        r_err, w_nerr;
  logic        r_done, w_ndone;
  logic        r_mode;
  logic [31:0] r_tot, r_duty;
  logic        w_latch, w_xfer, w_sel, w_en, w_bad_arg, w_stop_pend;
  logic [31:0] w_off, w_wdata;
  logic        w_unused;

  assign w_xfer      = !(r_state inside {S_IDLE, S_RUN});
  assign w_sel       = w_xfer && (r_ph != PH_GAP);
  assign w_en        = w_xfer && (r_ph == PH_ACCESS);
  assign w_bad_arg   = (tot_cnt == '0) || (mode && (duty_cnt > tot_cnt));
  assign w_stop_pend = r_stop || stop;
  assign w_unused    = ^PRDATA[31:2];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_ph    <= PH_GAP;
      r_stop  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_mode  <= 1'b0;
      r_tot   <= '0;
      r_duty  <= '0;
    end else begin
      r_state <= w_nstate;
      r_ph    <= w_nph;
      r_stop  <= w_nstop;
      r_err   <= w_nerr;
      r_done  <= w_ndone;
      if (w_latch) begin
        r_mode <= mode;
        r_tot  <= tot_cnt;
        r_duty <= duty_cnt;
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nph    = r_ph;
    w_nstop  = r_stop;
    w_nerr   = r_err;
    w_ndone  = 1'b0;
    w_latch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad_arg) begin
            w_nerr = 1'b1;
          end else begin
            w_latch  = 1'b1;
            w_nerr   = 1'b0;
            w_nstop  = 1'b0;
            w_nstate = S_W_CTRL0;
            w_nph    = PH_SETUP;
          end
        end
      end
      // RUN has PSEL low, so the teardown transfer can open with SETUP directly.
      S_RUN: begin
        if (stop || (!r_mode && irq)) begin
          w_nstate = S_W_CLR;
          w_nph    = PH_SETUP;
        end
      end
      S_W_CLR: begin
        case (r_ph)
          PH_GAP:   w_nph = PH_SETUP;
          PH_SETUP: w_nph = PH_ACCESS;
          default: if (PREADY) begin
            w_nstate = S_IDLE;
            w_nph    = PH_GAP;
            w_nstop  = 1'b0;
            if (PSLVERR) w_nerr = 1'b1;
            else         w_ndone = !r_err;
          end
        endcase
      end
      default: begin
        if (stop) w_nstop = 1'b1;
        case (r_ph)
          PH_GAP:   w_nph = PH_SETUP;
          PH_SETUP: w_nph = PH_ACCESS;
          default: if (PREADY) begin
            w_nph = PH_GAP;
            if (PSLVERR) begin
              w_nerr   = 1'b1;
              w_nstate = S_W_CLR;
            end else if (r_state == S_R_CHK && PRDATA[1:0] != {1'b1, r_mode}) begin
              w_nerr   = 1'b1;
              w_nstate = S_W_CLR;
            end else if (w_stop_pend) begin
              w_nstate = S_W_CLR;
            end else begin
              case (r_state)
                S_W_CTRL0: w_nstate = S_W_TOT;
                S_W_TOT:   w_nstate = r_mode ? S_W_DUTY : S_W_GO;
                S_W_DUTY:  w_nstate = S_W_GO;
                S_W_GO:    w_nstate = S_R_CHK;
                default:   w_nstate = S_RUN;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    w_off   = '0;
    w_wdata = '0;
    case (r_state)
      S_W_CTRL0: w_wdata = {30'd0, 1'b0, r_mode};
      S_W_TOT:   begin w_off = 32'h4; w_wdata = r_tot;  end
      S_W_DUTY:  begin w_off = 32'h8; w_wdata = r_duty; end
      S_W_GO:    w_wdata = {30'd0, 1'b1, r_mode};
      default:   ;
    endcase
  end

  assign PSEL    = w_sel;
  assign PENABLE = w_en;
  assign PWRITE  = w_sel && (r_state != S_R_CHK);
  assign PADDR   = w_sel ? (BASE_ADR + w_off) : '0;
  assign PWDATA  = w_sel ? w_wdata : '0;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign err     = r_err;
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Randomized bench for timer_seq_ctrl: APB slave model, transfer log and a
// list-based model of the expected programming sequence.
module tb_timer_seq_ctrl;
  localparam logic [31:0] B = 32'h44a00000;

  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} xfer_t;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        start = 1'b0, stop = 1'b0, mode = 1'b0, irq = 1'b0;
  logic [31:0] tot_cnt = '0, duty_cnt = '0;
  logic        busy, done, err, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0] PRDATA = '0;

  int n_chk = 0, n_fail = 0;
  int wait_n = 0, wcnt = 0, n_done = 0, proto_err = 0;
  bit slv_en = 0, corrupt = 0, prev_fin = 0;
  logic [31:0] ctrl_reg = '0, tot_reg = '0, duty_reg = '0, la = '0, ld = '0;
  logic        lw = 1'b0;
  xfer_t q[$];
  xfer_t eq[$];
  bit exp_err, exp_run;

  timer_seq_ctrl #(.BASE_ADR(B)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .stop(stop), .mode(mode),
    .tot_cnt(tot_cnt), .duty_cnt(duty_cnt), .irq(irq), .busy(busy), .done(done),
    .err(err), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: wait states, register file, error injection, transfer log, protocol watch.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (wcnt == 0) PREADY = 1'b1;
      else begin PREADY = 1'b0; wcnt--; end
    end else begin
      PREADY = 1'b0;
      wcnt = wait_n;
    end
    PRDATA  = ctrl_reg ^ {31'd0, corrupt};
    PSLVERR = PREADY && PSEL && PENABLE && slv_en && PADDR == B + 32'h4;
    if (PSEL && !PENABLE) begin
      la = PADDR; ld = PWDATA; lw = PWRITE;
      if (prev_fin) proto_err++;
    end
    if (PSEL && PENABLE && (PADDR !== la || PWDATA !== ld || PWRITE !== lw)) proto_err++;
    if (!PSEL && PENABLE) proto_err++;
    if (PSEL && PENABLE && PREADY) begin
      q.push_back('{PWRITE, PADDR, PWRITE ? PWDATA : PRDATA});
      if (PWRITE && !PSLVERR) begin
        if (PADDR == B) ctrl_reg = PWDATA;
        else if (PADDR == B + 32'h4) tot_reg = PWDATA;
        else if (PADDR == B + 32'h8) duty_reg = PWDATA;
      end
    end
    prev_fin = PSEL && PENABLE && PREADY;
    if (done) n_done++;
  end

  // Expected transfer list: program steps in order, cut short by a slave error,
  // a failed readback or a pending stop, always closed by a CTRL=0 write.
  function automatic void build_exp(input logic m, input logic [31:0] t, input logic [31:0] d,
                                    input int sidx, input int slv_i, input bit corr);
    xfer_t prog[$];
    logic [31:0] go;
    go = {30'd0, 1'b1, m};
    prog.push_back('{1'b1, B, {31'd0, m}});
    prog.push_back('{1'b1, B + 32'h4, t});
    if (m) prog.push_back('{1'b1, B + 32'h8, d});
    prog.push_back('{1'b1, B, go});
    prog.push_back('{1'b0, B, go ^ {31'd0, corr}});
    eq.delete();
    exp_err = 0;
    exp_run = 0;
    for (int i = 0; i < prog.size(); i++) begin
      eq.push_back(prog[i]);
      if (i == slv_i) begin exp_err = 1; break; end
      if (i == prog.size() - 1 && corr) begin exp_err = 1; break; end
      if (sidx >= 0 && i >= sidx) break;
      if (i == prog.size() - 1) exp_run = 1;
    end
    eq.push_back('{1'b1, B, 32'd0});
  endfunction

  task automatic run_seq(input string nm, input logic m, input logic [31:0] t, input logic [31:0] d,
                         input int wn, input int sidx, input bit slv, input bit corr,
                         input int dly, input bit both);
    int base, nd0, pe0, cyc, cnt, nprog;
    bit stop_sent, trig;
    wait_n = wn; slv_en = slv; corrupt = corr;
    build_exp(m, t, d, sidx, slv ? 1 : -1, corr);
    nprog = m ? 5 : 4;
    base = q.size(); nd0 = n_done; pe0 = proto_err;
    stop_sent = 0; trig = 0; cnt = 0; cyc = 0;
    @(negedge PCLK);
    start = 1'b1; mode = m; tot_cnt = t; duty_cnt = d;
    while (cyc < 5000) begin
      @(negedge PCLK);
      cyc++;
      start = 1'b0; stop = 1'b0;
      if (cyc == 3) begin start = 1'b1; mode = ~m; tot_cnt = '0; end
      if (sidx >= 0 && !stop_sent && PSEL && PADDR == (sidx == 1 ? B + 32'h4 : B + 32'h8)) begin
        stop = 1'b1; stop_sent = 1;
      end
      if (exp_run && !trig && q.size() - base >= nprog) begin
        cnt++;
        if (cnt == dly) begin
          trig = 1;
          if (m) stop = 1'b1;
          else begin irq = 1'b1; if (both) stop = 1'b1; end
        end
      end
      if (irq && q.size() > base + nprog && q[$] == '{1'b1, B, 32'd0}) irq = 1'b0;
      if (!busy) break;
    end
    irq = 1'b0;
    chk({nm, "_timeout"}, cyc < 5000, 1);
    repeat (2) @(negedge PCLK);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_done_cnt"}, n_done - nd0, exp_err ? 0 : 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_nxfer"}, q.size() - base, eq.size());
    for (int i = 0; i < eq.size() && base + i < q.size(); i++)
      chk($sformatf("%s_xfer%0d", nm, i), q[base + i], eq[i]);
    chk({nm, "_proto"}, proto_err - pe0, 0);
  endtask

  task automatic args_bad(input string nm, input logic m, input logic [31:0] t, input logic [31:0] d);
    int base, act;
    base = q.size(); act = 0;
    @(negedge PCLK);
    start = 1'b1; mode = m; tot_cnt = t; duty_cnt = d;
    repeat (6) begin
      @(negedge PCLK);
      start = 1'b0;
      if (PSEL || busy) act++;
    end
    chk({nm, "_err"}, err, 1);
    chk({nm, "_activity"}, act, 0);
    chk({nm, "_nxfer"}, q.size() - base, 0);
  endtask

  task automatic reset_in_go(input logic m);
    int base, cyc;
    wait_n = 3; slv_en = 0; corrupt = 0;
    base = q.size(); cyc = 0;
    @(negedge PCLK);
    start = 1'b1; mode = m; tot_cnt = 32'd200; duty_cnt = 32'd7;
    @(negedge PCLK);
    start = 1'b0;
    while (cyc < 500 && !(PSEL && PENABLE && PADDR == B && PWDATA[1])) begin
      @(negedge PCLK);
      cyc++;
    end
    chk("rst_reach_go", cyc < 500, 1);
    #1 PRESETn = 1'b0;
    #1 chk("rst_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy, done, err}, 0);
    chk("rst_nxfer", q.size() - base, m ? 3 : 2);
    repeat (3) @(negedge PCLK);
    chk("rst_held", {PSEL, busy}, 0);
    PRESETn = 1'b1;
  endtask

  initial begin
    int act;
    logic m;
    logic [31:0] t, d;
    #3 chk("reset_state", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy, done, err}, 0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;

    run_seq("cnt", 1'b0, 32'd128, 32'd0, 0, -1, 0, 0, 20, 0);
    run_seq("pwm", 1'b1, 32'd64, 32'd25, 0, -1, 0, 0, 600, 0);
    run_seq("slverr", 1'b1, 32'd50, 32'd5, 1, -1, 1, 0, 5, 0);
    run_seq("clr_err", 1'b0, 32'd9, 32'd0, 0, -1, 0, 0, 4, 0);
    args_bad("tot0", 1'b0, 32'd0, 32'd0);
    args_bad("duty_gt", 1'b1, 32'd10, 32'd11);
    run_seq("duty_eq", 1'b1, 32'd10, 32'd10, 1, -1, 0, 0, 8, 0);
    run_seq("ws_stop", 1'b1, 32'd77, 32'd3, 3, 1, 0, 0, 5, 0);
    run_seq("ws_stop_cnt", 1'b0, 32'd33, 32'd0, 3, 1, 0, 0, 5, 0);
    run_seq("irq_stop", 1'b0, 32'd40, 32'd0, 2, -1, 0, 0, 6, 1);
    run_seq("rd_bad", 1'b1, 32'd40, 32'd4, 0, -1, 0, 1, 6, 0);

    act = 0;
    @(negedge PCLK);
    stop = 1'b1;
    repeat (5) begin
      @(negedge PCLK);
      stop = 1'b0;
      if (PSEL || busy || done) act++;
    end
    chk("stop_idle", act, 0);

    reset_in_go(1'b1);
    chk("rst_err_clear", err, 0);
    run_seq("after_rst", 1'b0, 32'd15, 32'd0, 1, -1, 0, 0, 4, 0);

    for (int k = 0; k < 8; k++) begin
      m = 1'($urandom_range(0, 1));
      t = 32'($urandom_range(1, 1000));
      d = 32'($urandom_range(0, t));
      run_seq($sformatf("rnd%0d", k), m, t, d, $urandom_range(0, 3), -1, 0, 0,
              $urandom_range(2, 40), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
